// File: rtl/dmem_responder.sv
// Data-memory target for the RV32I load/store port: B/H/W accesses with sign/zero extension,
// byte-lane stores, a fixed number of wait states and an error response for illegal accesses.
module dmem_responder #(
  parameter int ANCHO       = 32,
  parameter int LARGO       = 1024,
  parameter int WAIT_STATES = 1,
  parameter     INIT_FILE   = ""
) (
  input  logic             CLOCK,
  input  logic             RST,
  input  logic             req_rd,
  input  logic             req_wr,
  input  logic [31:0]      addr,
  input  logic [ANCHO-1:0] din,
  input  logic [2:0]       size,
  output logic [ANCHO-1:0] dout,
  output logic             rsp_valid,
  output logic             rsp_err,
  output logic             busy
);
  localparam int         AW   = $clog2(LARGO);
  localparam logic [3:0] WS   = 4'(WAIT_STATES);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [31:0] a_q, d_q;
  logic [2:0]  sz_q;
  logic        rd_q, wr_q;

  logic [3:0][7:0] mem [LARGO];

  // With no wait states the access commits on the accept edge, so it must work from the live inputs.
  logic [31:0] c_addr, c_din;
  logic [2:0]  c_size;
  logic        c_rd, c_wr;
  always_comb begin
    if (WAIT_STATES == 0) begin
      c_addr = addr; c_din = din; c_size = size; c_rd = req_rd; c_wr = req_wr;
    end else begin
      c_addr = a_q;  c_din = d_q; c_size = sz_q; c_rd = rd_q;   c_wr = wr_q;
    end
  end

  logic [29:0]   widx;
  logic [AW-1:0] idx;
  logic          oor, mis, bad_sz, err;
  assign widx = c_addr[31:2];
  assign idx  = widx[AW-1:0];
  assign oor  = widx >= 30'(LARGO);

  always_comb begin
    mis    = 1'b0;
    bad_sz = 1'b0;
    case (c_size)
      3'b000:  ;
      3'b001:  mis = c_addr[0];
      3'b010:  mis = |c_addr[1:0];
      3'b100:  bad_sz = c_wr;
      3'b101:  begin bad_sz = c_wr; mis = c_addr[0]; end
      default: bad_sz = 1'b1;
    endcase
    err = (c_rd & c_wr) | bad_sz | mis | oor;
  end

  logic [31:0] rword, lane, ldata, wdata;
  logic [3:0]  we;
  assign rword = mem[idx];
  assign lane  = rword >> {c_addr[1:0], 3'b000};

  always_comb begin
    case (c_size)
      3'b000:  ldata = {{24{lane[7]}}, lane[7:0]};
      3'b100:  ldata = {24'd0, lane[7:0]};
      3'b001:  ldata = {{16{lane[15]}}, lane[15:0]};
      3'b101:  ldata = {16'd0, lane[15:0]};
      default: ldata = rword;
    endcase
    case (c_size[1:0])
      2'b00:   begin we = 4'b0001 << c_addr[1:0]; wdata = {4{c_din[7:0]}}; end
      2'b01:   begin we = c_addr[1] ? 4'b1100 : 4'b0011; wdata = {2{c_din[15:0]}}; end
      default: begin we = 4'b1111; wdata = c_din; end
    endcase
  end

  logic commit;
  assign commit = !RST &&
                  (((state == IDLE) && (req_rd || req_wr) && (WAIT_STATES == 0)) ||
                   ((state == WAIT) && (cnt == 4'd0)));
  assign busy = (state != IDLE);

  always_ff @(posedge CLOCK) begin
    if (commit && c_wr && !err)
      for (int i = 0; i < 4; i++)
        if (we[i]) mem[idx][i] <= wdata[8*i +: 8];
  end

  always_ff @(posedge CLOCK) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      dout      <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= commit;
      rsp_err   <= commit && err;
      if (commit && err)       dout <= '0;
      else if (commit && c_rd) dout <= ldata;
      case (state)
        IDLE: if (req_rd || req_wr) begin
          a_q   <= addr;
          d_q   <= din;
          sz_q  <= size;
          rd_q  <= req_rd;
          wr_q  <= req_wr;
          cnt   <= (WS == 4'd0) ? 4'd0 : WS - 4'd1;
          state <= (WS == 4'd0) ? RESP : WAIT;
        end
        WAIT: if (cnt == 4'd0) state <= RESP;
              else             cnt   <= cnt - 4'd1;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances (1, 3 and 0 wait states) driven with
// directed accesses; per-instance monitors check data, error flag and response cycle.
module tb_dmem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int vecs = 0, misc = 0;

  logic [2:0]  rst, req_rd, req_wr, busy, rsp_valid, rsp_err;
  logic [31:0] addr [3], din [3], dout [3];
  logic [2:0]  size [3];
  logic [31:0] last_dout [3];

  typedef struct packed {
    logic        err;
    logic [31:0] d;
    logic [31:0] cyc;
  } exp_t;
  exp_t q [3][$];

  function automatic int wsof(int d);
    return (d == 0) ? 1 : (d == 1) ? 3 : 0;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    vecs++;
    if (act !== expv) begin
      misc++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, expv);
    end
  endtask

  generate for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 0) ? 1 : (g == 1) ? 3 : 0;
    dmem_responder #(.ANCHO(32), .LARGO(1024), .WAIT_STATES(W), .INIT_FILE("")) u_dut (
      .CLOCK(clk), .RST(rst[g]), .req_rd(req_rd[g]), .req_wr(req_wr[g]),
      .addr(addr[g]), .din(din[g]), .size(size[g]), .dout(dout[g]),
      .rsp_valid(rsp_valid[g]), .rsp_err(rsp_err[g]), .busy(busy[g]));

    exp_t e;
    always @(negedge clk) begin
      if (rsp_valid[g] === 1'b1) begin
        if (q[g].size() == 0) begin
          misc++;
          $display("FAIL spurious_rsp dut%0d: got rsp_valid=1 expected 0 at cycle %0d", g, cyc);
        end else begin
          e = q[g].pop_front();
          chk($sformatf("rsp_err dut%0d", g), {31'd0, rsp_err[g]}, {31'd0, e.err});
          chk($sformatf("dout dut%0d", g), dout[g], e.d);
          chk($sformatf("rsp_cycle dut%0d", g), 32'(cyc), e.cyc);
        end
      end else if (rsp_err[g] !== 1'b0) begin
        misc++;
        $display("FAIL err_no_valid dut%0d: got rsp_err=%b expected 0", g, rsp_err[g]);
      end
    end
  end endgenerate

  task automatic wait_idle(int d);
    int t = 0;
    while (busy[d] && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (busy[d] !== 1'b0) begin
      misc++;
      $display("FAIL idle_timeout dut%0d: got busy=%b expected 0", d, busy[d]);
    end
  endtask

  // Issue one request held for 'hold' edges; queue one expectation per accept.
  task automatic xact(int d, bit rd, bit wr, logic [31:0] a, logic [31:0] dt, logic [2:0] sz,
                      bit e_err, logic [31:0] e_ld, int hold = 1);
    int w, n, bc;
    logic [31:0] ed;
    exp_t e;
    w = wsof(d);
    wait_idle(d);
    ed = e_err ? 32'd0 : (rd ? e_ld : last_dout[d]);
    last_dout[d] = ed;
    req_rd[d] = rd; req_wr[d] = wr; addr[d] = a; din[d] = dt; size[d] = sz;
    n = (hold + w + 1) / (w + 2);
    for (int i = 0; i < n; i++) begin
      e.err = e_err; e.d = ed; e.cyc = 32'(cyc + 1 + w + i * (w + 2));
      q[d].push_back(e);
    end
    repeat (hold) @(negedge clk);
    req_rd[d] = 1'b0; req_wr[d] = 1'b0;
    if (hold == 1) begin
      bc = 0;
      while (busy[d] && bc < 64) begin
        bc++;
        @(negedge clk);
      end
      chk($sformatf("busy_cycles dut%0d", d), 32'(bc), 32'(w + 1));
    end else wait_idle(d);
  endtask

  localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

  initial begin
    int t;
    rst = 3'b111; req_rd = '0; req_wr = '0;
    for (int d = 0; d < 3; d++) begin
      addr[d] = '0; din[d] = '0; size[d] = '0; last_dout[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_dout dut%0d", d), dout[d], 32'd0);
      chk($sformatf("reset_flags dut%0d", d), {29'd0, rsp_valid[d], rsp_err[d], busy[d]}, 32'd0);
    end
    rst = 3'b000;
    @(negedge clk);

    // word / byte / half accesses (1 wait state)
    xact(0, 0, 1, 32'h10, 32'hDEADBEEF, W,  0, 0);
    xact(0, 1, 0, 32'h10, 0,            W,  0, 32'hDEADBEEF);
    xact(0, 0, 1, 32'h11, 32'h00000080, B,  0, 0);
    xact(0, 1, 0, 32'h11, 0,            B,  0, 32'hFFFFFF80);
    xact(0, 1, 0, 32'h11, 0,            BU, 0, 32'h00000080);
    xact(0, 1, 0, 32'h10, 0,            W,  0, 32'hDEAD80EF);
    xact(0, 0, 1, 32'h12, 32'h00001234, H,  0, 0);
    xact(0, 1, 0, 32'h12, 0,            H,  0, 32'h00001234);
    xact(0, 1, 0, 32'h13, 0,            H,  1, 0);
    xact(0, 1, 0, 32'h10, 0,            W,  0, 32'h123480EF);
    xact(0, 0, 1, 32'h14, 32'hF00D8765, W,  0, 0);
    xact(0, 1, 0, 32'h14, 0,            H,  0, 32'hFFFF8765);
    xact(0, 1, 0, 32'h14, 0,            HU, 0, 32'h00008765);
    xact(0, 1, 0, 32'h17, 0,            B,  0, 32'hFFFFFFF0);
    xact(0, 1, 0, 32'h16, 0,            HU, 0, 32'h0000F00D);
    xact(0, 0, 1, 32'h13, 32'h000000AB, B,  0, 0);
    xact(0, 1, 0, 32'h10, 0,            W,  0, 32'hAB3480EF);

    // error responses leave memory alone
    xact(0, 0, 1, 32'h0,    32'hCAFEF00D, W,      0, 0);
    xact(0, 0, 1, 32'h1000, 32'h11111111, W,      1, 0);
    xact(0, 1, 0, 32'h0,    0,            W,      0, 32'hCAFEF00D);
    xact(0, 1, 1, 32'h0,    32'h22222222, W,      1, 0);
    xact(0, 1, 0, 32'h0,    0,            3'b011, 1, 0);
    xact(0, 0, 1, 32'h0,    32'h000000FF, BU,     1, 0);
    xact(0, 0, 1, 32'h2,    32'h33333333, W,      1, 0);
    xact(0, 1, 0, 32'h0,    0,            W,      0, 32'hCAFEF00D);
    xact(0, 0, 1, 32'hFFC,  32'h13579BDF, W,      0, 0);
    xact(0, 1, 0, 32'hFFC,  0,            W,      0, 32'h13579BDF);

    // reset in WAIT discards the pending store (3 wait states)
    xact(1, 0, 1, 32'h20, 32'h11111111, W, 0, 0);
    wait_idle(1);
    req_wr[1] = 1'b1; addr[1] = 32'h20; din[1] = 32'h22222222; size[1] = W;
    @(negedge clk);
    req_wr[1] = 1'b0;
    chk("busy_in_wait dut1", {31'd0, busy[1]}, 32'd1);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    chk("busy_after_rst dut1", {31'd0, busy[1]}, 32'd0);
    chk("dout_after_rst dut1", dout[1], 32'd0);
    last_dout[1] = '0;
    repeat (6) @(negedge clk);
    xact(1, 1, 0, 32'h20, 0, W, 0, 32'h11111111);

    // requests held high: one response per accept
    xact(0, 1, 0, 32'h10, 0, W, 0, 32'hAB3480EF, 6);
    xact(2, 0, 1, 32'h40, 32'h0000A5A5, W, 0, 0);
    xact(2, 1, 0, 32'h40, 0, W, 0, 32'h0000A5A5, 4);
    xact(2, 1, 0, 32'h40, 0, B, 0, 32'hFFFFFFA5);
    xact(2, 1, 0, 32'h41, 0, H, 1, 0);

    t = 0;
    while ((q[0].size() + q[1].size() + q[2].size()) != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("pending_responses", 32'(q[0].size() + q[1].size() + q[2].size()), 32'd0);
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, misc);
    $finish;
  end
endmodule
